// File: rtl/mu0_pkg.sv
// Shared definitions for the MU0 boot loader: loader FSM states, MU0 opcodes, default sizes.
package mu0_pkg;

  localparam int MEM_DEPTH_DEF = 32;
  localparam int ADDR_W_DEF    = 12;
  localparam int DATA_W_DEF    = 16;

  typedef enum logic [3:0] {
    LEN_HI = 4'd0,
    LEN_LO = 4'd1,
    DAT_HI = 4'd2,
    DAT_LO = 4'd3,
    WRITE  = 4'd4,
    CHK_HI = 4'd5,
    CHK_LO = 4'd6,
    RUN    = 4'd7,
    ERR    = 4'd8
  } load_state_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STO = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  // Host words travel high byte first.
  function automatic logic [15:0] pack_bytes(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/mu0_byte_packer.sv
// Hi/lo byte register pair with a phase flag; assembles 16-bit words from the host byte stream.
module mu0_byte_packer
  import mu0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        take,
  input  logic [7:0]  in_byte,
  output logic [15:0] word,
  output logic [15:0] word_comb,
  output logic        word_valid
);

  logic       phase_reg;
  logic [7:0] hi_reg;
  logic [7:0] lo_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else if (take) begin
      if (phase_reg) lo_reg <= in_byte;
      else           hi_reg <= in_byte;
      phase_reg <= ~phase_reg;
    end
  end

  // word_comb lets the FSM act on a word in the same cycle its low byte arrives.
  assign word       = pack_bytes(hi_reg, lo_reg);
  assign word_comb  = pack_bytes(hi_reg, in_byte);
  assign word_valid = take & phase_reg;

endmodule

// File: rtl/mu0_boot_loader.sv
// Length-prefixed byte-stream image loader for MU0 memory; releases the CPU and hands it the bus.
// Optional trailing 16-bit checksum enabled by defining BOOT_CHECKSUM_EN.
module mu0_boot_loader
  import mu0_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_memrq,
  input  logic              cpu_rnw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_memrq,
  output logic              mem_rnw,
  output logic              cpu_rst_n,
  output logic              load_done,
  output logic              load_err
);

  localparam int CNT_W = $clog2(MEM_DEPTH + 1);
  localparam logic [15:0] MAX_LEN = 16'(MEM_DEPTH);

`ifdef BOOT_CHECKSUM_EN
  localparam load_state_t LOADED = CHK_HI;
`else
  localparam load_state_t LOADED = RUN;
`endif

  load_state_t      state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [15:0]      len_reg, len_next;
  logic             cpu_rst_n_reg, load_done_reg, load_err_reg;
  logic             take, word_valid;
  logic [15:0]      word, word_comb;
`ifdef BOOT_CHECKSUM_EN
  logic [15:0]      sum_reg, sum_next;
`endif

  mu0_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .take       (take),
    .in_byte    (in_byte),
    .word       (word),
    .word_comb  (word_comb),
    .word_valid (word_valid)
  );

  assign in_ready = (state_reg == LEN_HI) || (state_reg == LEN_LO) ||
                    (state_reg == DAT_HI) || (state_reg == DAT_LO) ||
                    (state_reg == CHK_HI) || (state_reg == CHK_LO);
  assign take     = in_valid & in_ready;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    len_next   = len_reg;
`ifdef BOOT_CHECKSUM_EN
    sum_next   = sum_reg;
`endif
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_memrq  = 1'b0;
    mem_rnw    = 1'b1;
    case (state_reg)
      LEN_HI: if (take) state_next = LEN_LO;
      LEN_LO: begin
        if (word_valid) begin
          len_next = word_comb;
          if (word_comb == 16'h0000)  state_next = LOADED;
          else if (word_comb > MAX_LEN) state_next = ERR;
          else                          state_next = DAT_HI;
        end
      end
      DAT_HI: if (take) state_next = DAT_LO;
      DAT_LO: if (word_valid) state_next = WRITE;
      WRITE: begin
        mem_memrq  = 1'b1;
        mem_rnw    = 1'b0;
        mem_addr   = ADDR_W'(count_reg);
        mem_wdata  = DATA_W'(word);
        count_next = count_reg + CNT_W'(1);
`ifdef BOOT_CHECKSUM_EN
        sum_next   = sum_reg + word;
`endif
        state_next = (16'(count_next) == len_reg) ? LOADED : DAT_HI;
      end
`ifdef BOOT_CHECKSUM_EN
      CHK_HI: if (take) state_next = CHK_LO;
      CHK_LO: if (word_valid) state_next = (word_comb == sum_reg) ? RUN : ERR;
`endif
      RUN: begin
        // CPU owns the bus combinationally once the image is in place.
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_memrq = cpu_memrq;
        mem_rnw   = cpu_rnw;
      end
      ERR:     state_next = ERR;
      default: state_next = LEN_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= LEN_HI;
      count_reg     <= '0;
      len_reg       <= '0;
      cpu_rst_n_reg <= 1'b0;
      load_done_reg <= 1'b0;
      load_err_reg  <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum_reg       <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      len_reg       <= len_next;
      cpu_rst_n_reg <= (state_next == RUN);
      load_done_reg <= (state_next == RUN);
      load_err_reg  <= load_err_reg | (state_next == ERR);
`ifdef BOOT_CHECKSUM_EN
      sum_reg       <= sum_next;
`endif
    end
  end

  assign cpu_rst_n = cpu_rst_n_reg;
  assign load_done = load_done_reg;
  assign load_err  = load_err_reg;

endmodule
